// File: rtl/button_pkg.sv
// Shared definitions for the button press classifier and its debounce stage.
// Latency: none (types and constants only).
// Backpressure: none.
package button_pkg;

   // FSM state encoding
   localparam logic [2:0] WAIT_REL = 3'd0;
   localparam logic [2:0] IDLE     = 3'd1;
   localparam logic [2:0] PRESS1   = 3'd2;
   localparam logic [2:0] GAP      = 3'd3;
   localparam logic [2:0] PRESS2   = 3'd4;
   localparam logic [2:0] LONG     = 3'd5;

   typedef enum logic [2:0] {
      S_WAIT_REL = WAIT_REL,
      S_IDLE     = IDLE,
      S_PRESS1   = PRESS1,
      S_GAP      = GAP,
      S_PRESS2   = PRESS2,
      S_LONG     = LONG
   } state_t;

   // 500 ms and 250 ms at 25 MHz; shared with the debounce stage
   localparam int LONG_LIMIT_DEF = 12500000;
   localparam int DOUBLE_GAP_DEF = 6250000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button level in, classified event pulses and held level out.
// Latency: n/a (bundle of wires).
// Backpressure: none; pulses are fire-and-forget.
interface button_press_classifier_if;
   logic i_Debounced;
   logic o_Single;
   logic o_Double;
   logic o_Long;
   logic o_Held;

   modport master (output i_Debounced, input o_Single, o_Double, o_Long, o_Held);
   modport slave  (input i_Debounced, output o_Single, o_Double, o_Long, o_Held);
endinterface

// File: rtl/button_press_classifier.sv
// Classifies debounced button presses into single, double and long events.
// Latency: pulses are registered, high the cycle after the deciding sample.
// Backpressure: none; every event pulse lasts exactly one cycle.
module button_press_classifier
   import button_pkg::*;
#(
   parameter int LONG_LIMIT = LONG_LIMIT_DEF,
   parameter int DOUBLE_GAP = DOUBLE_GAP_DEF
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst,
   button_press_classifier_if.slave bus
);

   localparam int CW = $clog2(max2(LONG_LIMIT, DOUBLE_GAP) + 1);
   localparam logic [CW-1:0] LONG_C = CW'(LONG_LIMIT);
   localparam logic [CW-1:0] GAP_C  = CW'(DOUBLE_GAP);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   // Limits of 0 or 1 would let a single sample both start and finish a phase
   generate
      if (LONG_LIMIT < 2) begin : g_bad_long
         $error("button_press_classifier: LONG_LIMIT must be >= 2");
      end
      if (DOUBLE_GAP < 2) begin : g_bad_gap
         $error("button_press_classifier: DOUBLE_GAP must be >= 2");
      end
   endgenerate

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          single_q, single_d;
   logic          double_q, double_d;
   logic          long_q, long_d;
   logic          held_q, held_d;
   logic          in_lvl;

   assign in_lvl = bus.i_Debounced;

   // Next-state, counter and output pulse decisions from the current sample
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      single_d = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
      held_d   = held_q;
      cnt_inc  = cnt_q + ONE_C;
      case (state_q)
         S_WAIT_REL: begin
            if (!in_lvl) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_IDLE: begin
            if (in_lvl) begin
               state_d = S_PRESS1;
               cnt_d   = ONE_C;
            end
         end
         S_PRESS1: begin
            if (!in_lvl) begin
               state_d = S_GAP;
               cnt_d   = ONE_C;
            end else if (cnt_inc == LONG_C) begin
               long_d  = 1'b1;
               held_d  = 1'b1;
               state_d = S_LONG;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_GAP: begin
            // A press on the last gap sample still counts as a second click
            if (in_lvl) begin
               state_d = S_PRESS2;
               cnt_d   = ONE_C;
            end else if (cnt_inc == GAP_C) begin
               single_d = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_PRESS2: begin
            if (!in_lvl) begin
               double_d = 1'b1;
               state_d  = S_IDLE;
               cnt_d    = '0;
            end else if (cnt_inc == LONG_C) begin
               // Long second press still reports a double; wait for release
               double_d = 1'b1;
               state_d  = S_WAIT_REL;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_LONG: begin
            if (!in_lvl) begin
               held_d  = 1'b0;
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_WAIT_REL;
            cnt_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs; reset discards any pending click
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q  <= S_WAIT_REL;
         cnt_q    <= '0;
         single_q <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         single_q <= single_d;
         double_q <= double_d;
         long_q   <= long_d;
         held_q   <= held_d;
      end
   end

   assign bus.o_Single = single_q;
   assign bus.o_Double = double_q;
   assign bus.o_Long   = long_q;
   assign bus.o_Held   = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: a run-length reference model predicts events per sample,
// a negedge monitor pops and compares whenever the DUT pulses.
// Directed cases first, then randomized level runs with occasional resets.
module tb_button_press_classifier;

   localparam int LL = 8;
   localparam int DG = 5;
   localparam int K_SINGLE = 1;
   localparam int K_DOUBLE = 2;
   localparam int K_LONG   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_press_classifier_if bus ();

   button_press_classifier #(.LONG_LIMIT(LL), .DOUBLE_GAP(DG)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   typedef struct {
      int stamp;
      int kind;
   } ev_t;

   ev_t exp_q[$];
   bit  held_at[int];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: tracks run lengths of the sampled level and click count
   bit armed, long_active, have_prev, prev, cur_in;
   int clicks, run_len;

   function automatic void model_reset();
      armed = 1'b0;
      long_active = 1'b0;
      have_prev = 1'b0;
      prev = 1'b0;
      clicks = 0;
      run_len = 0;
   endfunction

   function automatic void push_ev(input int stamp, input int kind);
      ev_t e;
      e.stamp = stamp;
      e.kind = kind;
      exp_q.push_back(e);
   endfunction

   function automatic void model_step(input bit v, input int stamp);
      if (have_prev && v == prev) run_len++;
      else run_len = 1;
      prev = v;
      have_prev = 1'b1;
      if (!armed) begin
         if (!v) armed = 1'b1;
      end else if (long_active) begin
         if (!v) long_active = 1'b0;
      end else if (v) begin
         if (run_len == 1) clicks++;
         if (clicks > 0 && run_len == LL) begin
            if (clicks == 1) begin
               push_ev(stamp, K_LONG);
               long_active = 1'b1;
            end else begin
               push_ev(stamp, K_DOUBLE);
               armed = 1'b0;
            end
            clicks = 0;
         end
      end else begin
         if (clicks == 2 && run_len == 1) begin
            push_ev(stamp, K_DOUBLE);
            clicks = 0;
         end else if (clicks == 1 && run_len == DG) begin
            push_ev(stamp, K_SINGLE);
            clicks = 0;
         end
      end
      held_at[stamp] = long_active;
   endfunction

   // Monitor: compare DUT outputs against the scoreboard every falling edge
   always @(negedge clk) begin
      int kind;
      ev_t e;
      if (rst) begin
         n_checks++;
         if ({bus.o_Single, bus.o_Double, bus.o_Long, bus.o_Held} != 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%b%b%b%b want=0000", cyc,
                     bus.o_Single, bus.o_Double, bus.o_Long, bus.o_Held);
         end
      end else begin
         n_checks++;
         if (int'(bus.o_Single) + int'(bus.o_Double) + int'(bus.o_Long) > 1) begin
            n_fail++;
            $display("FAIL one_hot cyc=%0d got S=%b D=%b L=%b want at most one",
                     cyc, bus.o_Single, bus.o_Double, bus.o_Long);
         end
         if (bus.o_Single || bus.o_Double || bus.o_Long) begin
            kind = bus.o_Single ? K_SINGLE : (bus.o_Double ? K_DOUBLE : K_LONG);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pulse cyc=%0d got kind=%0d want none", cyc, kind);
            end else begin
               e = exp_q.pop_front();
               if (e.stamp != cyc || e.kind != kind) begin
                  n_fail++;
                  $display("FAIL pulse cyc=%0d got kind=%0d want kind=%0d at cyc=%0d",
                           cyc, kind, e.kind, e.stamp);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
            n_checks++;
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL missed_pulse cyc=%0d got none want kind=%0d at cyc=%0d",
                     cyc, e.kind, e.stamp);
         end
         if (held_at.exists(cyc)) begin
            n_checks++;
            if (bus.o_Held !== held_at[cyc]) begin
               n_fail++;
               $display("FAIL held cyc=%0d got=%b want=%b", cyc, bus.o_Held, held_at[cyc]);
            end
            held_at.delete(cyc);
         end
      end
   end

   task automatic drive(input bit v, input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
         bus.i_Debounced = v;
         cur_in = v;
         model_step(v, cyc + 1);
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      #2;
      rst = 1'b0;
      model_step(cur_in, cyc + 1);
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.o_Single, bus.o_Double, bus.o_Long, bus.o_Held} != 4'b0000) begin
         n_fail++;
         $display("FAIL async_reset got=%b%b%b%b want=0000",
                  bus.o_Single, bus.o_Double, bus.o_Long, bus.o_Held);
      end
      exp_q.delete();
      model_reset();
      repeat (ncyc) @(posedge clk);
      release_rst();
   endtask

   initial begin
      bit lvl;
      int len;
      int pick;
      model_reset();
      cur_in = 1'b1;
      bus.i_Debounced = 1'b1;
      repeat (3) @(negedge clk);

      // Reset while held, then a single click
      release_rst();
      drive(1'b1, 20);
      drive(1'b0, 1);
      drive(1'b1, 3);
      drive(1'b0, 5);
      drive(1'b0, 3);

      // Single click
      drive(1'b1, 3);
      drive(1'b0, 5);
      drive(1'b0, 2);

      // Double click
      drive(1'b1, 3);
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 1);
      drive(1'b0, 6);

      // Gap boundary: last gap sample vs one past it
      drive(1'b1, 2);
      drive(1'b0, 4);
      drive(1'b1, 2);
      drive(1'b0, 1);
      drive(1'b0, 6);
      drive(1'b1, 2);
      drive(1'b0, 5);
      drive(1'b1, 2);
      drive(1'b0, 5);
      drive(1'b0, 2);

      // Long press
      drive(1'b1, 12);
      drive(1'b0, 3);

      // Double click whose second press runs to the long limit
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 10);
      drive(1'b0, 3);

      // Reset mid-GAP
      drive(1'b1, 3);
      drive(1'b0, 2);
      do_reset(2);
      drive(1'b0, 10);

      // Randomized runs, biased toward the limits
      lvl = 1'b1;
      for (int i = 0; i < 80; i++) begin
         pick = $urandom_range(0, 3);
         if (pick == 0) begin
            case ($urandom_range(0, 3))
               0: len = LL - 1;
               1: len = LL;
               2: len = DG - 1;
               default: len = DG;
            endcase
         end else begin
            len = $urandom_range(1, 12);
         end
         drive(lvl, len);
         lvl = ~lvl;
         if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2));
      end

      drive(1'b0, 12);
      @(negedge clk);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies presses of one debounced push-button into single-click, double-click and long-press events, and reports when a long hold is in progress. It sits directly downstream of the debounce filter and takes that filter's clean, clock-synchronous level as its input. It produces one-cycle event pulses for the control/UI logic further down the design.

## Interface
- LONG_LIMIT, default 12500000: consecutive high samples that make a long press (500 ms at 25 MHz); must be ≥ 2.
- DOUBLE_GAP, default 6250000: low samples after a first click before it is declared single (250 ms at 25 MHz); must be ≥ 2.
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Debounced  input  1  debounced button level, 1 = pressed; synchronous to i_Clk, so no synchronizer is used.
- o_Single  output  1  one-cycle pulse: single click.
- o_Double  output  1  one-cycle pulse: double click.
- o_Long  output  1  one-cycle pulse: long press reached.
- o_Held  output  1  level: long press still held.

## Operation
- All outputs are registered. At most one pulse output is high in any cycle.
- One shared counter, cnt, has width $clog2(max(LONG_LIMIT, DOUBLE_GAP) + 1).
  - cnt counts samples taken in the current phase.
  - It never exceeds its limit, because reaching the limit always forces a transition.
- A parameter below 2 triggers an elaboration-time error.
- WAIT_REL (the reset state): leave for IDLE on the first sample of 0. A button held through reset therefore produces no event.
- IDLE: on a sample of 1, go to PRESS1 with cnt = 1.
- PRESS1:
  - Sample 1: cnt+1. When cnt+1 == LONG_LIMIT, pulse o_Long, set o_Held, and go to LONG.
  - Sample 0: go to GAP with cnt = 1.
- GAP:
  - Sample 1: go to PRESS2 with cnt = 1.
  - Sample 0: cnt+1. When cnt+1 == DOUBLE_GAP, pulse o_Single and go to IDLE.
- PRESS2:
  - Sample 0: pulse o_Double and go to IDLE.
  - Sample 1: cnt+1. When cnt+1 == LONG_LIMIT, pulse o_Double (no o_Long, no o_Held) and go to WAIT_REL.
- LONG: on a sample of 0, clear o_Held and go to IDLE.
- When a single edge meets two conditions, the input level decides. For example, in GAP with cnt = DOUBLE_GAP−1:
  - a high sample goes to PRESS2 with no o_Single;
  - a low sample gives o_Single.
- A press of 1 high sample (a one-cycle blip that passed the debounce filter) is a valid click.

## Timing
- Reset (asynchronous):
  - All outputs go to 0 immediately, state = WAIT_REL, cnt = 0.
  - Any pending click is discarded; no late o_Single.
  - Release of reset is synchronized by the system.
- Sample n means the value of i_Debounced at rising edge n.
- Pulses are high during the cycle after the deciding edge, i.e. registered one cycle after the deciding sample:
  - o_Long / o_Held: after the LONG_LIMIT-th consecutive high sample.
  - o_Single: after the DOUBLE_GAP-th consecutive low sample that follows the first click.
  - o_Double: after the first low sample ending the second press, or after the LONG_LIMIT-th high sample of the second press.
- o_Held falls in the cycle after the first low sample in LONG.
- A new press is accepted on the sample immediately after the event edge (IDLE reacts to that sample); there is no dead time.

## Structure
- Shared package button_pkg holds:
  - the state encoding as localparams (WAIT_REL, IDLE, PRESS1, GAP, PRESS2, LONG; 3 bits);
  - the default LONG_LIMIT and DOUBLE_GAP values, so that the debounce stage and this block use one clock-rate basis.
- No sub-module. The counter and FSM are inline: one sequential process plus next-state logic.

## Test plan
All tests use LONG_LIMIT = 8, DOUBLE_GAP = 5.
- **Reset while held:** input 1 across reset release for 20 cycles, then 0, then 3 highs and 5 lows → no pulse during the hold; o_Single one cycle after the 5th low.
- **Single click:** 3 highs, then 5 lows → o_Single high exactly one cycle after the 5th low; o_Double and o_Long stay 0.
- **Double click:** 3 highs, 2 lows, 3 highs, 1 low → o_Double one cycle after that low; o_Single never pulses.
- **Gap boundary:**
  - 2 highs, 4 lows, 2 highs, 1 low → o_Double.
  - 2 highs, 5 lows, 2 highs, 5 lows → o_Single after the 5th low, then a second o_Single.
- **Long press:** 12 highs, then 0 → o_Long pulse and o_Held rise one cycle after the 8th high; o_Held falls one cycle after the first low; no other pulse.
- **Reset mid-GAP:** 3 highs, 2 lows, assert i_Rst for 2 cycles, then hold low for 10 cycles → all outputs 0 throughout; no o_Single.
